// File: rtl/sn_bitstream_gen.sv
// Binary-to-stochastic encoder: turns NUM_LANES signed bipolar values into
// exact-count bitstreams of 2^WIDTH beats using a bit-reversed counter sequence.
module sn_bitstream_gen #(
    parameter int WIDTH     = 4,
    parameter int NUM_LANES = 4
) (
    input  logic                       i_clk_udc,
    input  logic                       i_rst_udc,
    input  logic                       i_start,
    input  logic                       i_abort,
    input  logic [NUM_LANES*WIDTH-1:0] i_x,
    input  logic                       i_ready,
    output logic                       o_valid,
    output logic [NUM_LANES-1:0]       o_sn_bit,
    output logic                       o_last,
    output logic                       o_busy,
    output logic                       o_done
);

    localparam int               L       = 1 << WIDTH;
    localparam logic [WIDTH-1:0] CNT_MAX = WIDTH'(L - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        GEN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t                     state_reg, state_next;
    logic [WIDTH-1:0]           cnt_reg, cnt_next;
    logic [NUM_LANES*WIDTH-1:0] x_reg, x_next;
    logic [WIDTH-1:0]           cnt_rev;

    always_ff @(posedge i_clk_udc or posedge i_rst_udc) begin
        if (i_rst_udc) begin
            state_reg <= IDLE;
            cnt_reg   <= '0;
            x_reg     <= '0;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
            x_reg     <= x_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        x_next     = x_reg;
        case (state_reg)
            IDLE: begin
                if (i_start && !i_abort) begin
                    x_next     = i_x;
                    cnt_next   = '0;
                    state_next = GEN;
                end
            end
            GEN: begin
                // Abort wins over completion: the stream simply stops without a done pulse.
                if (i_abort) begin
                    cnt_next   = '0;
                    state_next = IDLE;
                end else if (i_ready) begin
                    if (cnt_reg == CNT_MAX) begin
                        cnt_next   = '0;
                        state_next = DONE;
                    end else begin
                        cnt_next = cnt_reg + WIDTH'(1);
                    end
                end
            end
            DONE: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
                cnt_next   = '0;
            end
        endcase
    end

    assign o_valid = (state_reg == GEN);
    assign o_busy  = (state_reg == GEN);
    assign o_done  = (state_reg == DONE);
    assign o_last  = o_valid && (cnt_reg == CNT_MAX);

    for (genvar gi = 0; gi < WIDTH; gi++) begin : g_rev
        assign cnt_rev[gi] = cnt_reg[WIDTH-1-gi];
    end

    // Each lane XORs a distinct constant into the shared sequence; still a permutation of 0..L-1.
    for (genvar gi = 0; gi < NUM_LANES; gi++) begin : g_lane
        localparam logic [WIDTH-1:0] LANE_KEY = WIDTH'(gi % L);
        logic [WIDTH-1:0] u_val;
        logic [WIDTH-1:0] r_val;
        assign u_val        = x_reg[gi*WIDTH +: WIDTH] ^ {1'b1, {(WIDTH-1){1'b0}}};
        assign r_val        = cnt_rev ^ LANE_KEY;
        assign o_sn_bit[gi] = o_valid && (r_val < u_val);
    end

endmodule

// File: tb/tb_sn_bitstream_gen.sv
// Directed testbench for sn_bitstream_gen: per-lane ones counts, timing of
// last/done/busy, backpressure, abort, start-ignore and asynchronous reset.
module tb_sn_bitstream_gen;

    logic        clk;
    logic        rst;
    logic        start;
    logic        abort_s;
    logic [15:0] x_in;
    logic        ready;
    logic        valid;
    logic [3:0]  sn_bit;
    logic        last;
    logic        busy;
    logic        done;

    int checks = 0;
    int errors = 0;

    // stream statistics gathered by the collector
    int          ones [4];
    logic [3:0]  ud [4];
    int          xfers, busy_cyc, done_cyc, done_cnt, last_cnt, last_idx;
    logic        unstable, nonzero_idle;
    logic [15:0] lane0_bits;

    sn_bitstream_gen #(.WIDTH(4), .NUM_LANES(4)) dut (
        .i_clk_udc (clk),
        .i_rst_udc (rst),
        .i_start   (start),
        .i_abort   (abort_s),
        .i_x       (x_in),
        .i_ready   (ready),
        .o_valid   (valid),
        .o_sn_bit  (sn_bit),
        .o_last    (last),
        .o_busy    (busy),
        .o_done    (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish, errors=%0d", errors);
        $fatal(1, "timeout");
    end

    task automatic do_start(input logic [15:0] xv);
        @(negedge clk);
        x_in    = xv;
        start   = 1'b1;
        abort_s = 1'b0;
        ready   = 1'b1;
    endtask

    // Consumes one stream; optional 3-cycle stalls at two beat indices and start spamming.
    task automatic collect(input int stall_a, input int stall_b, input bit spam);
        int   stall_left;
        bit   used_a, used_b, prev_stalled;
        logic [3:0] prev_bits;
        logic prev_last;
        stall_left = 0; used_a = 0; used_b = 0; prev_stalled = 0;
        prev_bits = '0; prev_last = 1'b0;
        for (int k = 0; k < 4; k++) begin
            ones[k] = 0;
            ud[k]   = 4'd0;
        end
        xfers = 0; busy_cyc = 0; done_cyc = 0; done_cnt = 0; last_cnt = 0; last_idx = -1;
        unstable = 1'b0; nonzero_idle = 1'b0; lane0_bits = '0;
        for (int cyc = 1; cyc <= 100; cyc++) begin
            @(negedge clk);
            if (spam) begin
                start = busy || done;
                x_in  = 16'h8888;
            end else begin
                start = 1'b0;
            end
            if (valid && xfers == stall_a && !used_a) begin stall_left = 3; used_a = 1; end
            if (valid && xfers == stall_b && !used_b) begin stall_left = 3; used_b = 1; end
            ready = (stall_left == 0);
            if (prev_stalled && (sn_bit !== prev_bits || last !== prev_last)) unstable = 1'b1;
            if (!valid && sn_bit !== 4'b0) nonzero_idle = 1'b1;
            if (busy) busy_cyc++;
            if (done) begin
                done_cnt++;
                if (done_cyc == 0) done_cyc = cyc;
            end
            if (valid && ready) begin
                for (int k = 0; k < 4; k++) begin
                    ones[k] += int'(sn_bit[k]);
                    ud[k] = sn_bit[k] ? ud[k] + 4'd1 : ud[k] - 4'd1;
                end
                if (xfers < 16) lane0_bits[xfers] = sn_bit[0];
                if (last) begin
                    last_cnt++;
                    last_idx = xfers;
                end
                xfers++;
            end
            prev_stalled = valid && !ready;
            prev_bits    = sn_bit;
            prev_last    = last;
            if (stall_left > 0) stall_left--;
            if (done_cyc != 0 && cyc > done_cyc) break;
        end
        start = 1'b0;
        ready = 1'b1;
        $display("stream: xfers=%0d ones=%0d/%0d/%0d/%0d done_cyc=%0d busy=%0d",
                 xfers, ones[0], ones[1], ones[2], ones[3], done_cyc, busy_cyc);
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b0; abort_s = 1'b0; x_in = '0; ready = 1'b0;
        repeat (2) @(negedge clk);
        checks++;
        if ({valid, sn_bit, last, busy, done} !== 8'b0) begin
            errors++;
            $display("FAIL reset_outputs: got %b expected 00000000", {valid, sn_bit, last, busy, done});
        end
        rst = 1'b0;
        // start together with abort must be refused in IDLE
        @(negedge clk);
        x_in = 16'hF087; start = 1'b1; abort_s = 1'b1; ready = 1'b1;
        @(negedge clk);
        start = 1'b0; abort_s = 1'b0;
        checks++;
        if (busy !== 1'b0 || valid !== 1'b0) begin
            errors++;
            $display("FAIL start_with_abort: got busy=%b valid=%b expected 0 0", busy, valid);
        end
        $display("test_reset done");
    endtask

    task automatic check_stream(input string name, input int e0, input int e1, input int e2,
                                input int e3, input int exp_done, input int exp_busy);
        int exp_ones [4];
        exp_ones = '{e0, e1, e2, e3};
        checks++;
        if (xfers !== 16) begin
            errors++;
            $display("FAIL %s_xfers: got %0d expected 16", name, xfers);
        end
        for (int k = 0; k < 4; k++) begin
            checks++;
            if (ones[k] !== exp_ones[k]) begin
                errors++;
                $display("FAIL %s_ones_lane%0d: got %0d expected %0d", name, k, ones[k], exp_ones[k]);
            end
        end
        checks++;
        if (last_cnt !== 1 || last_idx !== 15) begin
            errors++;
            $display("FAIL %s_last: got count=%0d idx=%0d expected 1 at 15", name, last_cnt, last_idx);
        end
        checks++;
        if (done_cyc !== exp_done || done_cnt !== 1) begin
            errors++;
            $display("FAIL %s_done: got cyc=%0d count=%0d expected cyc=%0d count=1", name, done_cyc, done_cnt, exp_done);
        end
        checks++;
        if (busy_cyc !== exp_busy) begin
            errors++;
            $display("FAIL %s_busy: got %0d expected %0d", name, busy_cyc, exp_busy);
        end
        checks++;
        if (nonzero_idle !== 1'b0) begin
            errors++;
            $display("FAIL %s_bits_when_invalid: got nonzero expected 0", name);
        end
    endtask

    task automatic test_basic();
        do_start(16'hF087);
        collect(-1, -1, 1'b0);
        check_stream("basic", 15, 0, 8, 7, 17, 16);
        checks++;
        if ({ud[3], ud[2], ud[1], ud[0]} !== {4'd14, 4'd0, 4'd0, 4'd14}) begin
            errors++;
            $display("FAIL basic_updown: got %h expected e00e", {ud[3], ud[2], ud[1], ud[0]});
        end
        checks++;
        if (lane0_bits !== 16'h7FFF) begin
            errors++;
            $display("FAIL basic_lane0_bits: got %h expected 7fff", lane0_bits);
        end
    endtask

    task automatic test_pattern();
        do_start(16'hF080);
        collect(-1, -1, 1'b0);
        check_stream("pattern", 8, 0, 8, 7, 17, 16);
        checks++;
        if (lane0_bits !== 16'h5555) begin
            errors++;
            $display("FAIL pattern_lane0_bits: got %h expected 5555", lane0_bits);
        end
        checks++;
        if (ud[0] !== 4'd0) begin
            errors++;
            $display("FAIL pattern_updown: got %0d expected 0", ud[0]);
        end
    endtask

    task automatic test_backpressure();
        do_start(16'hF087);
        collect(5, 11, 1'b0);
        check_stream("stall", 15, 0, 8, 7, 23, 22);
        checks++;
        if (unstable !== 1'b0) begin
            errors++;
            $display("FAIL stall_stability: got outputs changing expected stable");
        end
    endtask

    task automatic test_abort();
        int  n;
        bit  hit;
        bit  saw_done;
        n = 0; hit = 0; saw_done = 0;
        do_start(16'hF087);
        for (int cyc = 0; cyc < 40; cyc++) begin
            @(negedge clk);
            start = 1'b0;
            if (valid && n == 6) begin
                abort_s = 1'b1;
                hit = 1;
                break;
            end
            if (valid) n++;
        end
        @(negedge clk);
        abort_s = 1'b0;
        checks++;
        if (!hit || valid !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin
            errors++;
            $display("FAIL abort_idle: got hit=%0d valid=%b busy=%b done=%b expected 1 0 0 0", hit, valid, busy, done);
        end
        repeat (3) begin
            @(negedge clk);
            if (done || valid) saw_done = 1;
        end
        checks++;
        if (saw_done) begin
            errors++;
            $display("FAIL abort_no_done: got activity after abort expected none");
        end
        $display("abort at beat %0d", n);
        do_start(16'hF087);
        collect(-1, -1, 1'b0);
        check_stream("after_abort", 15, 0, 8, 7, 17, 16);
    endtask

    task automatic test_start_ignore();
        do_start(16'hF087);
        collect(-1, -1, 1'b1);
        check_stream("spam", 15, 0, 8, 7, 17, 16);
        @(negedge clk);
        checks++;
        if (busy !== 1'b0 || valid !== 1'b0) begin
            errors++;
            $display("FAIL spam_idle: got busy=%b valid=%b expected 0 0", busy, valid);
        end
    endtask

    task automatic test_async_reset();
        int  n;
        bit  hit;
        n = 0; hit = 0;
        do_start(16'hF087);
        for (int cyc = 0; cyc < 40; cyc++) begin
            @(negedge clk);
            start = 1'b0;
            if (valid && n == 9) begin
                hit = 1;
                break;
            end
            if (valid) n++;
        end
        #2 rst = 1'b1;
        #1;
        checks++;
        if (!hit || {valid, sn_bit, last, busy, done} !== 8'b0) begin
            errors++;
            $display("FAIL async_reset: got hit=%0d outputs=%b expected 1 00000000", hit, {valid, sn_bit, last, busy, done});
        end
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if (valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_release_idle: got valid=%b expected 0", valid);
        end
        do_start(16'hF087);
        collect(-1, -1, 1'b0);
        check_stream("after_reset", 15, 0, 8, 7, 17, 16);
    endtask

    initial begin
        test_reset();
        test_basic();
        test_pattern();
        test_backpressure();
        test_abort();
        test_start_ignore();
        test_async_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
